// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multi-cycle MIPS core: owns the PC, reads imem over req/ack and holds the IR for decode.
// Optional macro HALT_ON_ILLEGAL_EN stops fetch on an opcode outside {R-type, lw, sw, beq}.
module instr_fetch_unit #(
  parameter int unsigned                PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]        RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic [31:0]         ir,
  output logic [5:0]          opcode,
  output logic                ir_valid,
  input  logic                ir_ready,
  input  logic                branch_taken,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'd4};

`ifdef HALT_ON_ILLEGAL_EN
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction
`endif

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [31:0]         ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic                req_q, req_d;
  logic                halted_q, halted_d;
  logic [PC_WIDTH-1:0] br_off_s;

  // Sign-extended word offset of a beq immediate, already scaled to bytes.
  assign br_off_s = {{(PC_WIDTH-18){ir_q[15]}}, ir_q[15:0], 2'b00};

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    req_d      = req_q;
    halted_d   = halted_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
      end
      S_FETCH: begin
        // An ack only counts against a request actually on the bus.
        if (req_q && imem_ack) begin
          ir_d  = imem_rdata;
          req_d = 1'b0;
`ifdef HALT_ON_ILLEGAL_EN
          if (!is_legal_op(imem_rdata[31:26])) begin
            halted_d   = 1'b1;
            ir_valid_d = 1'b0;
            state_d    = S_HALT;
          end else begin
            ir_valid_d = 1'b1;
            state_d    = S_VALID;
          end
`else
          ir_valid_d = 1'b1;
          state_d    = S_VALID;
`endif
        end else begin
          req_d = 1'b1;
        end
      end
      S_VALID: begin
        if (ir_ready) begin
          ir_valid_d = 1'b0;
          req_d      = 1'b1;
          state_d    = S_FETCH;
          if (branch_taken) begin
            pc_d = pc_plus4_q + br_off_s;
          end else begin
            pc_d = pc_plus4_q;
          end
          pc_plus4_d = pc_d + PC_STEP;
        end else begin
          state_d = S_VALID;
        end
      end
      S_HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        req_d      = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + PC_STEP;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[31:26];
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit (RESET_PC = 0x100), plus reset and illegal-opcode sequences.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_taken;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .ir(ir), .opcode(opcode), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_taken(branch_taken), .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
  );

  typedef struct {
    logic [31:0] word;
    int          ack_dly;
    int          rdy_dly;
    logic        bt;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[10];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (imem_req !== 1'b1) check("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    int w;
    // word, ack delay, ready delay, branch_taken, expected fetch address
    vecs[0] = '{32'h8C01_0004, 0, 0, 1'b0, 32'h0000_0100};
    vecs[1] = '{32'h0022_1820, 0, 0, 1'b0, 32'h0000_0104};
    vecs[2] = '{32'hAC03_0008, 0, 0, 1'b0, 32'h0000_0108};
    vecs[3] = '{32'h8C44_0010, 3, 5, 1'b0, 32'h0000_010C};
    vecs[4] = '{32'h1000_003B, 0, 0, 1'b1, 32'h0000_0110};
    vecs[5] = '{32'h1000_FFFF, 0, 0, 1'b1, 32'h0000_0200};
    vecs[6] = '{32'h1000_0004, 0, 0, 1'b1, 32'h0000_0200};
    vecs[7] = '{32'h1000_FF79, 0, 0, 1'b1, 32'h0000_0214};
    vecs[8] = '{32'h1000_0005, 0, 0, 1'b0, 32'hFFFF_FFFC};
    vecs[9] = '{32'h0000_0000, 1, 2, 1'b0, 32'h0000_0000};

    rst_n = 1'b0; imem_rdata = 32'h0; imem_ack = 1'b0; ir_ready = 1'b0; branch_taken = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, RPC);
    check("rst_pc_plus4", pc_plus4, RPC + 32'd4);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    #1 check("req_after_release", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("req_cycle1", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("req_cycle2", {31'd0, imem_req}, 32'd1);
    check("addr_first", imem_addr, RPC);

    for (int i = 0; i < 10; i++) begin
      wait_req(w);
      if (i > 0) check("throughput", w, 0);
      check("fetch_addr", imem_addr, vecs[i].exp_addr);
      check("fetch_pc_plus4", pc_plus4, vecs[i].exp_addr + 32'd4);
      for (int k = 0; k < vecs[i].ack_dly; k++) begin
        @(negedge clk);
        check("req_hold", {31'd0, imem_req}, 32'd1);
      end
      imem_ack = 1'b1; imem_rdata = vecs[i].word;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = 32'h5A5A_5A5A;
      check("ir_valid_set", {31'd0, ir_valid}, 32'd1);
      check("ir_word", ir, vecs[i].word);
      check("opcode", {26'd0, opcode}, {26'd0, vecs[i].word[31:26]});
      check("pc_in_valid", pc, vecs[i].exp_addr);
      check("req_dropped", {31'd0, imem_req}, 32'd0);
      for (int k = 0; k < vecs[i].rdy_dly; k++) begin
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; branch_taken = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; branch_taken = 1'b0;
        check("stall_ir", ir, vecs[i].word);
        check("stall_pc", pc, vecs[i].exp_addr);
        check("stall_valid", {31'd0, ir_valid}, 32'd1);
      end
      ir_ready = 1'b1; branch_taken = vecs[i].bt;
      @(negedge clk);
      ir_ready = 1'b0; branch_taken = 1'b0;
      check("ir_valid_clr", {31'd0, ir_valid}, 32'd0);
    end
    wait_req(w);
    check("addr_after_wrap", imem_addr, 32'h0000_0004);

    // Reset in the middle of a fetch, then an ack that arrives too late.
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc, RPC);
    check("midrst_ir", ir, 32'h0);
    check("midrst_valid", {31'd0, ir_valid}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h8C00_1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_ir", ir, 32'h0);
    check("late_ack_valid", {31'd0, ir_valid}, 32'd0);
    check("refetch_req", {31'd0, imem_req}, 32'd1);
    check("refetch_addr", imem_addr, RPC);

    // Opcode 000010 (j): halts with the macro, passes through without it.
    imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
    @(negedge clk);
    imem_ack = 1'b0;
    check("illegal_ir", ir, 32'h0800_0010);
`ifdef HALT_ON_ILLEGAL_EN
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, ir_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      ir_ready = 1'b1;
      @(negedge clk);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_pc", pc, RPC);
    end
    ir_ready = 1'b0;
`else
    check("no_halt_flag", {31'd0, halted}, 32'd0);
    check("no_halt_valid", {31'd0, ir_valid}, 32'd1);
    check("no_halt_opcode", {26'd0, opcode}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
